// File: rtl/fetch_stage.sv
// Fetch stage: program counter, next-PC selection and the IF/ID pipeline register.
// Optional stall/flush performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_enable,
  input  logic             instr_enable,
  input  logic             pc_src,
  input  logic             jumpD,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      imem_addr,
  output logic [31:0]      instrD,
  output logic [31:0]      pc_plus4D,
`ifdef FETCH_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             validD
);

  logic [31:0] pcReg;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4;
  logic [31:0] branchAligned;
  logic [31:0] jumpAligned;

  logic [31:0] instrReg;
  logic [31:0] instrNext;
  logic [31:0] pcPlus4Reg;
  logic [31:0] pcPlus4Next;
  logic        validReg;
  logic        validNext;

  logic        redirect;
  logic        ifIdStall;
  logic        flushApplied;

  // Target low bits are discarded so the PC stays word aligned.
  logic        unusedTargetBits;
  assign unusedTargetBits = &{1'b0, branch_target[1:0], jump_target[1:0]};

  assign branchAligned = {branch_target[31:2], 2'b00};
  assign jumpAligned   = {jump_target[31:2], 2'b00};
  assign pcPlus4       = pcReg + 32'd4;

  assign redirect      = pc_src | jumpD;
  assign ifIdStall     = ~instr_enable;
  assign flushApplied  = instr_enable & redirect;

  // ---------------------------------------------------------------
  // Next-PC selection: hold > branch > jump > sequential
  // ---------------------------------------------------------------
  always_comb begin
    pcNext = pcReg;
    if (pc_enable) begin
      if (pc_src) begin
        pcNext = branchAligned;
      end else if (jumpD) begin
        pcNext = jumpAligned;
      end else begin
        pcNext = pcPlus4;
      end
    end
  end

  // ---------------------------------------------------------------
  // IF/ID next value: a stall holds and silently drops any redirect
  // ---------------------------------------------------------------
  always_comb begin
    instrNext   = instrReg;
    pcPlus4Next = pcPlus4Reg;
    validNext   = validReg;
    if (!ifIdStall) begin
      if (redirect) begin
        instrNext   = NOP_INSTR;
        pcPlus4Next = 32'd0;
        validNext   = 1'b0;
      end else begin
        instrNext   = imem_instr;
        pcPlus4Next = pcPlus4;
        validNext   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= RESET_PC;
    end else begin
      pcReg <= pcNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instrReg   <= NOP_INSTR;
      pcPlus4Reg <= 32'd0;
      validReg   <= 1'b0;
    end else begin
      instrReg   <= instrNext;
      pcPlus4Reg <= pcPlus4Next;
      validReg   <= validNext;
    end
  end

  assign imem_addr = pcReg;
  assign instrD    = instrReg;
  assign pc_plus4D = pcPlus4Reg;
  assign validD    = validReg;

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] stallCntReg;
  logic [CNT_W-1:0] stallCntNext;
  logic [CNT_W-1:0] flushCntReg;
  logic [CNT_W-1:0] flushCntNext;

  always_comb begin
    stallCntNext = stallCntReg;
    if (ifIdStall && (stallCntReg != {CNT_W{1'b1}})) begin
      stallCntNext = stallCntReg + 1'b1;
    end
  end

  always_comb begin
    flushCntNext = flushCntReg;
    if (flushApplied && (flushCntReg != {CNT_W{1'b1}})) begin
      flushCntNext = flushCntReg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      stallCntReg <= stallCntNext;
      flushCntReg <= flushCntNext;
    end
  end

  assign stall_cnt = stallCntReg;
  assign flush_cnt = flushCntReg;
`else
  logic             unusedFlushApplied;
  logic [CNT_W-1:0] unusedCntW;
  assign unusedFlushApplied = flushApplied;
  assign unusedCntW         = '0;
`endif

  // Holding the PC while reloading IF/ID duplicates an instruction; the
  // hazard unit should never request it.
  property pIllegalHoldCombo;
    @(posedge clk) disable iff (reset) !(!pc_enable && instr_enable);
  endproperty
  aIllegalHoldCombo: assert property (pIllegalHoldCombo)
    else $error("fetch_stage: pc_enable=0 with instr_enable=1 duplicates the fetched instruction");

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Consumer side of the hazard-detection stall/flush interface.
- Owns the program counter, the next-PC selection and the IF/ID pipeline register.
- Applies PC hold, IF/ID hold and flush-to-NOP exactly as commanded by pc_enable, instr_enable, pc_src and jumpD.
- Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush/reset (sll $0,$0,0).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pc_enable  input  1  1 = PC may update; 0 = PC holds
- instr_enable  input  1  1 = IF/ID may update; 0 = IF/ID holds
- pc_src  input  1  branch taken, resolved in ID
- jumpD  input  1  jump decoded in ID
- branch_target  input  32  branch destination from ID
- jump_target  input  32  jump destination from ID
- imem_instr  input  32  instruction at imem_addr (combinational memory read)
- imem_addr  output  32  current PC, drives instruction memory
- instrD  output  32  IF/ID instruction
- pc_plus4D  output  32  IF/ID PC+4
- validD  output  1  1 = instrD is a real fetched instruction; 0 = bubble

Behaviour:
- Reset (synchronous, sampled on rising clk, overrides everything):
  - PC <= RESET_PC; instrD <= NOP_INSTR; pc_plus4D <= 0; validD <= 0.
  - Performance counters <= 0.
- imem_addr = PC, combinational; no extra latency. Fetch-to-decode latency is 1 cycle.
- PC update (per cycle, reset low):
  - pc_enable=0: PC holds.
  - else pc_src=1: PC <= {branch_target[31:2],2'b00}.
  - else jumpD=1: PC <= {jump_target[31:2],2'b00}.
  - else PC <= PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
  - pc_src has priority over jumpD when both are high.
- PC[1:0] is always 2'b00; target low bits are ignored.
- IF/ID update (per cycle, reset low):
  - instr_enable=0: instrD, pc_plus4D and validD hold. Stall beats flush; a flush request during a stall is dropped, not deferred.
  - else (pc_src|jumpD)=1: flush. instrD <= NOP_INSTR, pc_plus4D <= 0, validD <= 0.
  - else: instrD <= imem_instr, pc_plus4D <= PC+4, validD <= 1.
- Illegal combination pc_enable=0 with instr_enable=1: PC holds and IF/ID reloads the same instruction (duplicate). No special handling; simulation assertion flags it.
- Reset asserted mid-stall or mid-flush: reset wins that cycle. Normal operation resumes the cycle after reset deasserts, with fetch from RESET_PC.
- No internal FSM beyond the registers above. Behaviour is fully defined by the priority order reset > stall > redirect > sequential.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - stall_cnt increments each cycle with instr_enable=0.
  - flush_cnt increments each cycle a flush is applied (instr_enable=1 and (pc_src|jumpD)=1).
  - Both counters saturate at all-ones (no wrap) and clear on reset.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset then 3 free-running cycles with imem_instr=32'h2008_0005 -> imem_addr 0,4,8,12. After cycle 1, instrD=32'h2008_0005, pc_plus4D=4, validD=1.
- At PC=0x10, pulse pc_enable=0 and instr_enable=0 for 2 cycles -> imem_addr stays 0x10. IF/ID holds the PC=0x0C entry (pc_plus4D=0x10) for 2 cycles, then resumes at 0x14.
- At PC=0x20, pc_src=1 with branch_target=0x0000_0103 -> next imem_addr=0x100; instrD=NOP_INSTR, validD=0 for one cycle.
- pc_src=1 and jumpD=1 together (branch_target=0x40, jump_target=0x80) -> PC=0x40, single flush. Separately, jumpD=1 with instr_enable=0 -> no flush; IF/ID holds.
- PC=0xFFFF_FFFC with no redirect -> next PC=0x0000_0000. Then assert reset during a stall -> PC=RESET_PC, validD=0 next cycle.
- With FETCH_PERF_EN, CNT_W=4: 20 stall cycles -> stall_cnt saturates at 4'hF. 1 flush -> flush_cnt=1. Reset -> both 0.
